// File: rtl/aes_key_buf_128.sv
// rtl/aes_key_buf_128.sv - AES-128 round-key buffer: captures rk0..rk10 from the expander, replays them forward or reverse
module aes_key_buf_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [31:0]  wi_0,
    input  logic [31:0]  wi_1,
    input  logic [31:0]  wi_2,
    input  logic [31:0]  wi_3,
    input  logic         rd_start,
    input  logic         rd_rev,
    input  logic         rk_rdy,
    output logic         ready,
    output logic         busy,
    output logic         rk_vld,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_last
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_READY  = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd10;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic           rev_q, rev_d;
    logic           ready_q, ready_d;
    logic           vld_q, vld_d;
    logic           last_q, last_d;
    logic [127:0]   rk_q, rk_d;

    logic [127:0]   kb [0:10];
    logic           kb_we;
    logic [3:0]     step_idx;
    logic [3:0]     first_idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rev_d     = rev_q;
        ready_d   = ready_q;
        vld_d     = vld_q;
        last_d    = last_q;
        rk_d      = rk_q;
        kb_we     = 1'b0;
        step_idx  = rev_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
        first_idx = rd_rev ? LAST_IDX : 4'd0;

        // A key load restarts capture from any state and drops the stream.
        if (kld) begin
            state_d = S_LOAD;
            cnt_d   = 4'd0;
            ready_d = 1'b0;
            vld_d   = 1'b0;
            last_d  = 1'b0;
            idx_d   = 4'd0;
            rk_d    = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    kb_we = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_READY;
                        ready_d = 1'b1;
                        cnt_d   = 4'd0;
                    end
                end
                S_READY: begin
                    if (rd_start) begin
                        state_d = S_STREAM;
                        rev_d   = rd_rev;
                        idx_d   = first_idx;
                        rk_d    = kb[first_idx];
                        vld_d   = 1'b1;
                        last_d  = 1'b0;
                    end
                end
                S_STREAM: begin
                    if (rk_rdy) begin
                        if (last_q) begin
                            state_d = S_READY;
                            vld_d   = 1'b0;
                            last_d  = 1'b0;
                            idx_d   = 4'd0;
                            rk_d    = '0;
                        end else begin
                            idx_d  = step_idx;
                            rk_d   = kb[step_idx];
                            last_d = rev_q ? (step_idx == 4'd0) : (step_idx == LAST_IDX);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 4'd0;
            rev_q   <= 1'b0;
            ready_q <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            rk_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rev_q   <= rev_d;
            ready_q <= ready_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            rk_q    <= rk_d;
        end
    end

    // Key storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (kb_we) begin
            kb[cnt_q] <= {wi_0, wi_1, wi_2, wi_3};
        end
    end

    assign ready   = ready_q;
    assign busy    = (state_q == S_LOAD) || (state_q == S_STREAM);
    assign rk_vld  = vld_q;
    assign rk      = rk_q;
    assign rk_idx  = idx_q;
    assign rk_last = last_q;

endmodule

// File: tb/tb_aes_key_buf_128.sv
// tb/tb_aes_key_buf_128.sv - self-checking bench for aes_key_buf_128 with an AES-128 key-expansion reference
module tb_aes_key_buf_128;

    logic         clk = 1'b0;
    logic         rst, kld, rd_start, rd_rev, rk_rdy;
    logic [31:0]  wi_0, wi_1, wi_2, wi_3;
    logic         ready, busy, rk_vld, rk_last;
    logic [127:0] rk;
    logic [3:0]   rk_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int beats, cycles;

    logic [7:0]   sbox [256];
    logic [127:0] aes_rk [11];
    logic [127:0] feed_rk [11];
    logic [127:0] model_kb [11];
    logic [127:0] got_rk [11];

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        logic [127:0] key;
        bit           rev;
        int           mode;
        bit           poke;
        logic [127:0] first;
        bit           has2;
        logic [127:0] second;
        logic [127:0] last;
    } vec_t;

    aes_key_buf_128 dut (
        .clk(clk), .rst(rst), .kld(kld),
        .wi_0(wi_0), .wi_1(wi_1), .wi_2(wi_2), .wi_3(wi_3),
        .rd_start(rd_start), .rd_rev(rd_rev), .rk_rdy(rk_rdy),
        .ready(ready), .busy(busy), .rk_vld(rk_vld),
        .rk(rk), .rk_idx(rk_idx), .rk_last(rk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, xb;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]] ^ rc, sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 11; n++) aes_rk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endtask

    task automatic set_wi(input logic [127:0] v);
        {wi_0, wi_1, wi_2, wi_3} = v;
    endtask

    // Plays the expander's side after the kld edge: one round key per cycle.
    task automatic feed(input bit poke_load);
        for (int n = 0; n < 11; n++) begin
            set_wi(feed_rk[n]);
            check("ready_low_in_load", ready, 0);
            check("busy_in_load", busy, 1);
            check("vld_low_in_load", rk_vld, 0);
            if (poke_load && n == 3) rd_start = 1'b1;
            tick();
            rd_start = 1'b0;
            model_kb[n] = feed_rk[n];
        end
        check("ready_after_11", ready, 1);
        check("busy_after_load", busy, 0);
    endtask

    task automatic capture(input bit poke_load);
        kld = 1'b1;
        tick();
        kld = 1'b0;
        feed(poke_load);
    endtask

    // mode 0: rk_rdy held 1, mode 1: toggles 1,0,..., mode 2: random
    task automatic stream(input bit rev, input int mode, input bit poke);
        bit rdy;
        int exp_idx;
        rd_start = 1'b1; rd_rev = rev; rk_rdy = 1'b0;
        tick();
        rd_start = 1'b0; rd_rev = 1'b0;
        beats = 0; cycles = 0;
        while (beats < 11 && cycles < 100) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rk_rdy  = rdy;
            exp_idx = rev ? 10 - beats : beats;
            check("stream_vld", rk_vld, 1);
            check("stream_rk", rk, model_kb[exp_idx]);
            check("stream_idx", rk_idx, exp_idx);
            check("stream_last", rk_last, beats == 10);
            if (poke && (cycles == 3 || (rdy && beats == 10))) rd_start = 1'b1;
            if (rdy) begin
                got_rk[beats] = rk;
                beats++;
            end
            tick();
            rd_start = 1'b0;
            cycles++;
        end
        rk_rdy = 1'b0;
        check("stream_beats", beats, 11);
        check("vld_fall", rk_vld, 0);
        check("rk_zero_idle", rk, 0);
        check("idx_zero_idle", rk_idx, 0);
        check("last_zero_idle", rk_last, 0);
        check("ready_kept", ready, 1);
        check("busy_after_stream", busy, 0);
        tick();
        check("no_restart", rk_vld, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ready"}, ready, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_vld"}, rk_vld, 0);
        check({name, "_rk"}, rk, 0);
        check({name, "_idx"}, rk_idx, 0);
        check({name, "_last"}, rk_last, 0);
    endtask

    task automatic rand_keys();
        for (int n = 0; n < 11; n++) feed_rk[n] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        vec_t tbl [4];
        tbl[0] = '{FIPS_KEY, 1'b1, 0, 1'b0, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                   1'b0, 128'h0, FIPS_KEY};
        tbl[1] = '{FIPS_KEY, 1'b0, 1, 1'b1, FIPS_KEY,
                   1'b1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        tbl[2] = '{128'h0, 1'b1, 0, 1'b0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                   1'b0, 128'h0, 128'h0};
        tbl[3] = '{128'h0, 1'b0, 2, 1'b1, 128'h0,
                   1'b1, 128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        init_sbox();
        rst = 1'b1; kld = 1'b0; rd_start = 1'b0; rd_rev = 1'b0; rk_rdy = 1'b0;
        set_wi(128'h0);
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;

        rd_start = 1'b1; rd_rev = 1'b1;
        tick();
        rd_start = 1'b0; rd_rev = 1'b0;
        check("idle_rd_start_vld", rk_vld, 0);
        check("idle_rd_start_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            expand(tbl[i].key);
            feed_rk = aes_rk;
            capture(i == 0);
            stream(tbl[i].rev, tbl[i].mode, tbl[i].poke);
            check("tbl_first", got_rk[0], tbl[i].first);
            check("tbl_last", got_rk[10], tbl[i].last);
            if (tbl[i].has2) check("tbl_second", got_rk[1], tbl[i].second);
            if (tbl[i].mode == 0) check("tbl_cycles_rdy1", cycles, 11);
            if (tbl[i].mode == 1) check("tbl_cycles_toggle", cycles <= 22, 1);
        end

        // kld during the 5th beat aborts the stream and reloads an all-zero key
        expand(FIPS_KEY);
        feed_rk = aes_rk;
        capture(1'b0);
        rd_start = 1'b1; rd_rev = 1'b0; rk_rdy = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (4) tick();
        check("beat5_idx", rk_idx, 4);
        kld = 1'b1;
        tick();
        kld = 1'b0; rk_rdy = 1'b0;
        check("abort_vld", rk_vld, 0);
        check("abort_ready", ready, 0);
        check("abort_rk", rk, 0);
        expand(128'h0);
        feed_rk = aes_rk;
        feed(1'b0);
        stream(1'b1, 0, 1'b0);
        check("abort_zero_rk10", got_rk[0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // reset in the middle of a capture
        kld = 1'b1;
        tick();
        kld = 1'b0;
        for (int n = 0; n < 6; n++) begin
            set_wi({$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst_in_load");
        for (int n = 0; n < 15; n++) begin
            check("ready_low_after_rst", ready, 0);
            tick();
        end
        rand_keys();
        capture(1'b0);
        stream(1'b0, 2, 1'b0);

        // kld held for four edges with junk on wi
        kld = 1'b1;
        repeat (4) begin
            set_wi({$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        kld = 1'b0;
        expand(FIPS_KEY);
        feed_rk = aes_rk;
        feed(1'b0);
        stream(1'b0, 0, 1'b0);
        check("held_kld_rk0", got_rk[0], FIPS_KEY);

        repeat (6) begin
            rand_keys();
            capture(1'($urandom_range(0, 1)));
            stream(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
